// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: drives one column low per slot, debounces the
// active-low rows and hands one key code per press to the consumer over valid/ready.
module keypad_scan #(
    parameter int SCAN_DIV     = 10_000,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      row_meta_q, row_s_q;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [1:0]      col_q, col_d;
    logic [1:0]      row_sel_q, row_sel_d;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic [DW-1:0]   rel_cnt_q, rel_cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic            overrun_q, overrun_d;

    logic            tick;
    logic            emit;
    logic            sel_low;
    logic [1:0]      first_row;

    assign tick    = (tick_cnt_q == TW'(SCAN_DIV - 1));
    assign sel_low = ~row_s_q[row_sel_q];

    always_comb begin
        first_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s_q[i]) first_row = 2'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        col_d       = col_q;
        row_sel_d   = row_sel_q;
        db_cnt_d    = db_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        emit        = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (row_s_q == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_sel_d = first_row;
                        db_cnt_d  = DW'(1);
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    // Only the latched row matters; other rows cannot restart the count.
                    if (sel_low) begin
                        if (db_cnt_q + DW'(1) == DW'(DEBOUNCE_CNT)) begin
                            state_d   = HELD;
                            rel_cnt_d = '0;
                            emit      = 1'b1;
                        end else begin
                            db_cnt_d = db_cnt_q + DW'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                HELD: begin
                    if (!sel_low) begin
                        if (rel_cnt_q + DW'(1) == DW'(DEBOUNCE_CNT)) begin
                            state_d   = SCAN;
                            rel_cnt_d = '0;
                            col_d     = col_q + 2'd1;
                        end else begin
                            rel_cnt_d = rel_cnt_q + DW'(1);
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        // A new key may replace one being accepted on the same edge.
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = {row_sel_q, col_q};
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    assign key_held_d = (state_d == HELD);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= SCAN;
            row_meta_q  <= 4'hF;
            row_s_q     <= 4'hF;
            tick_cnt_q  <= '0;
            col_q       <= 2'd0;
            row_sel_q   <= 2'd0;
            db_cnt_q    <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_meta_q  <= row_in;
            row_s_q     <= row_meta_q;
            tick_cnt_q  <= tick_cnt_d;
            col_q       <= col_d;
            row_sel_q   <= row_sel_d;
            db_cnt_q    <= db_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign col_out[gi] = (col_q != 2'(gi));
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4x4 matrix model: pressed[r*4+c]
// pulls row r low while column c is driven.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_held;
    logic        overrun;
    logic [15:0] pressed = 16'h0;

    int vectors = 0;
    int miscompares = 0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n * 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_cols [3];
        exp_cols = '{4'b1011, 4'b0111, 4'b1110};
        clr_n = 1'b0;
        pressed = 16'h0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({col_out, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_outputs: got col=%b code=%0d v=%b h=%b o=%b, expected col=1110 code=0 v=0 h=0 o=0",
                     col_out, key_code, key_valid, key_held, overrun);
        end
        clr_n = 1'b1;
        clk_n(3);
        vectors++;
        if (col_out !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_col_before_tick: got %b expected 1110", col_out);
        end
        clk_n(1);
        vectors++;
        if (col_out !== 4'b1101) begin
            miscompares++;
            $display("FAIL first_tick_col: got %b expected 1101", col_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            vectors++;
            if (col_out !== exp_cols[i] || key_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL scan_step%0d: got col=%b v=%b expected col=%b v=0", i, col_out, key_valid, exp_cols[i]);
            end
        end
        $display("test_reset: scan cycled through 4 columns");
    endtask

    task automatic test_press_release;
        key_ready = 1'b1;
        pressed = 16'h0;
        pressed[9] = 1'b1;
        tick_n(3);
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL early_valid: got %b expected 0", key_valid);
        end
        tick_n(1);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL press9: got v=%b code=%0d h=%b expected v=1 code=9 h=1", key_valid, key_code, key_held);
        end
        clk_n(1);
        vectors++;
        if (key_valid !== 1'b0 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL press9_accept: got v=%b h=%b expected v=0 h=1", key_valid, key_held);
        end
        clk_n(3);
        pressed = 16'h0;
        tick_n(2);
        vectors++;
        if (key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL release_early: got held=%b expected 1", key_held);
        end
        tick_n(1);
        vectors++;
        if (key_held !== 1'b0 || col_out !== 4'b1011) begin
            miscompares++;
            $display("FAIL release9: got h=%b col=%b expected h=0 col=1011", key_held, col_out);
        end
        $display("test_press_release: key 9 pressed and released");
    endtask

    task automatic test_bounce;
        pressed = 16'h0;
        pressed[3] = 1'b1;
        tick_n(2);
        vectors++;
        if (col_out !== 4'b0111 || key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_detect: got col=%b v=%b expected col=0111 v=0", col_out, key_valid);
        end
        pressed = 16'h0;
        tick_n(1);
        vectors++;
        if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_drop: got col=%b v=%b h=%b expected col=1110 v=0 h=0", col_out, key_valid, key_held);
        end
        $display("test_bounce: one-tick glitch on key 3 ignored");
    endtask

    task automatic test_overrun;
        key_ready = 1'b0;
        pressed = 16'h0;
        pressed[9] = 1'b1;
        tick_n(4);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_first: got v=%b code=%0d o=%b expected v=1 code=9 o=0", key_valid, key_code, overrun);
        end
        pressed = 16'h0;
        tick_n(3);
        vectors++;
        if (key_held !== 1'b0 || col_out !== 4'b1011 || key_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_release: got h=%b col=%b v=%b expected h=0 col=1011 v=1", key_held, col_out, key_valid);
        end
        pressed[4] = 1'b1;
        tick_n(5);
        vectors++;
        if (key_code !== 4'd9 || key_valid !== 1'b1 || overrun !== 1'b1 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_lost: got code=%0d v=%b o=%b h=%b expected code=9 v=1 o=1 h=1",
                     key_code, key_valid, overrun, key_held);
        end
        key_ready = 1'b1;
        clk_n(1);
        key_ready = 1'b0;
        vectors++;
        if (key_valid !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_accept: got v=%b o=%b expected v=0 o=1", key_valid, overrun);
        end
        clk_n(3);
        pressed = 16'h0;
        tick_n(3);
        vectors++;
        if (overrun !== 1'b1 || key_held !== 1'b0 || col_out !== 4'b1101) begin
            miscompares++;
            $display("FAIL ovr_sticky: got o=%b h=%b col=%b expected o=1 h=0 col=1101", overrun, key_held, col_out);
        end
        $display("test_overrun: key 4 lost behind undelivered key 9");
    endtask

    task automatic test_two_rows;
        key_ready = 1'b1;
        pressed = 16'h0;
        pressed[4] = 1'b1;
        pressed[12] = 1'b1;
        tick_n(5);
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL two_rows_early: got v=%b expected 0", key_valid);
        end
        tick_n(1);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd4 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL two_rows_code: got v=%b code=%0d h=%b expected v=1 code=4 h=1", key_valid, key_code, key_held);
        end
        clk_n(4);
        pressed[12] = 1'b0;
        tick_n(4);
        vectors++;
        if (key_held !== 1'b1 || col_out !== 4'b1110 || key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL two_rows_hold: got h=%b col=%b v=%b expected h=1 col=1110 v=0", key_held, col_out, key_valid);
        end
        $display("test_two_rows: rows 1+3 at col 0 gave key 4");
    endtask

    task automatic test_reset_mid_held;
        pressed = 16'h0;
        tick_n(3);
        vectors++;
        if (key_held !== 1'b0 || col_out !== 4'b1101) begin
            miscompares++;
            $display("FAIL pre_rst_release: got h=%b col=%b expected h=0 col=1101", key_held, col_out);
        end
        key_ready = 1'b0;
        pressed[9] = 1'b1;
        tick_n(3);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_press: got v=%b code=%0d h=%b expected v=1 code=9 h=1", key_valid, key_code, key_held);
        end
        clr_n = 1'b0;
        #2;
        vectors++;
        if ({col_out, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL async_reset: got col=%b code=%0d v=%b h=%b o=%b expected col=1110 code=0 v=0 h=0 o=0",
                     col_out, key_code, key_valid, key_held, overrun);
        end
        pressed = 16'h0;
        @(negedge clk);
        clr_n = 1'b1;
        tick_n(8);
        vectors++;
        if (key_valid !== 1'b0 || key_held !== 1'b0 || col_out !== 4'b1110) begin
            miscompares++;
            $display("FAIL post_rst_idle: got v=%b h=%b col=%b expected v=0 h=0 col=1110", key_valid, key_held, col_out);
        end
        pressed[9] = 1'b1;
        tick_n(4);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL post_rst_press: got v=%b code=%0d o=%b expected v=1 code=9 o=0", key_valid, key_code, overrun);
        end
        $display("test_reset_mid_held: reset discarded pending key, fresh press delivered");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_overrun();
        test_two_rows();
        test_reset_mid_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
